result_mem_wr: RTL and testbench
================================

Name: result_mem_wr

Overview:
Write-side counterpart of the BRAM read interfaces feeding the MAC array. It captures the four accumulator lanes (acc_out_0..3 / valid_out) as results appear and buffers them per lane. It serialises them, one word per cycle, onto the write port of an output BRAM in row-major order (row r, lane l -> base + r*N_MACS + l). Sits between mac_array outputs and the result BRAM; started and monitored by top-level control via start/busy/done.

Parameters:
ACC_W, 16, lane result width and BRAM word width
N_MACS, 4, lane count (block is built for exactly 4 lanes)
MEM_DEPTH, 256, output BRAM depth; ADDR_W = $clog2(MEM_DEPTH)
LANE_DEPTH, 2, per-lane FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a job when idle
base_addr  in  ADDR_W  first BRAM address, sampled on start
num_rows  in  ADDR_W  results expected per lane, sampled on start
acc_in_0..acc_in_3  in  ACC_W each (signed)  lane results
valid_in  in  N_MACS  per-lane result strobe; bit l qualifies acc_in_l
out_bram_addr  out  ADDR_W  write address
out_bram_en  out  1  BRAM enable
out_bram_we  out  1  write enable (always equal to out_bram_en)
out_bram_din  out  ACC_W  write data
busy  out  1  high in RUN
done  out  1  one-cycle pulse at job completion
err  out  2  sticky: [0] lane overflow, [1] extra result beyond num_rows

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, err=0, out_bram_en/we=0, out_bram_addr=0, out_bram_din=0. FIFOs are emptied, row counters zeroed, and the RR pointer is set to lane 0. Reset mid-job abandons the job; no further writes occur.
- States: IDLE -> RUN on start; RUN -> DONE when every lane's written count == num_rows and all FIFOs are empty and no write is pending on the output register; DONE -> IDLE after one cycle (done=1 only in DONE).
- start while busy or in DONE is ignored. start with num_rows=0 goes IDLE->DONE directly; done pulses in the next cycle and no writes occur.
- On start: err is cleared, row counters and FIFOs are cleared, and the RR pointer is set to 0.
- Capture (RUN only): each edge, for each lane l with valid_in[l]=1:
  - if lane l's accepted count < num_rows and its FIFO is not full, push acc_in_l;
  - if the FIFO is full, drop the value and set err[0];
  - if the accepted count >= num_rows, drop the value and set err[1].
  - A push into a full FIFO in the same cycle as a pop from that FIFO is accepted and is not an overflow.
  - valid_in is ignored outside RUN.
- Arbitration: each cycle, grant the first non-empty lane searching from the RR pointer upward (mod 4). After granting lane g, pointer = g+1 mod 4. At most one pop per cycle.
- Write: the popped value is registered into out_bram_din, with out_bram_addr = (base_addr + row[g]*N_MACS + g) mod MEM_DEPTH, and en=we=1 for exactly that cycle. row[g] is the lane's written count, incremented on pop. The address is computed at ADDR_W bits and wraps.
- Latency: a value sampled at edge k into an uncontended lane appears with en=1 in the cycle after edge k+1 (2 edges).
- Throughput: 1 word/cycle aggregate. Four lanes strobing every cycle overflow once the FIFOs fill; this is by design and flagged in err[0].
- err bits hold until next start or reset.

Optional Feature:
RESULT_MEM_WR_RELU_EN: when defined, each value is passed through ReLU at capture (negative -> 0, otherwise unchanged) before being pushed. When undefined, values are written bit-exact. Address, timing and flags are identical in both builds.

Test Plan:
- Reset then idle: valid_in=4'hF for 5 cycles with no start -> no out_bram_en, err=0, busy=0.
- start base=8, num_rows=1; lanes 0..3 strobe together with 5,-3,7,9 -> four writes on consecutive cycles: addr 8,9,10,11 with data 5,-3,7,9; done one cycle after the last write; busy falls with done. With RELU_EN, addr 9 data is 0.
- base=254, num_rows=1, all lanes strobe -> addresses 254,255,0,1 (wrap).
- num_rows=3, all lanes strobe 3 cycles back-to-back -> err[0]=1. Repeat with strobes spaced 4 cycles apart -> 12 writes, addr base..base+11 in row-major order, err=0.
- num_rows=1, lane 2 strobes twice -> second value dropped, err[1]=1. Job completes only after lanes 0, 1 and 3 deliver.
- Assert rst during a job after 2 writes -> outputs clear immediately. A subsequent start/job runs normally from base with err=0.

Source files
------------

// File: rtl/result_mem_wr.sv
// result_mem_wr: captures the four MAC accumulator lanes into small per-lane
// FIFOs and drains them round-robin, one word per cycle, onto the write port
// of the result BRAM in row-major order (row r, lane l -> base + r*4 + l).
// Build option: define RESULT_MEM_WR_RELU_EN to clamp negative results to
// zero at capture; otherwise results are written bit-exact.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | capturing lane results and writing them out
// DONE   | one-cycle completion pulse
module result_mem_wr #(
  parameter int  ACC_W      = 16,
  parameter int  N_MACS     = 4,
  parameter int  MEM_DEPTH  = 256,
  parameter int  LANE_DEPTH = 2,
  localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       num_rows,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  output logic [ADDR_W-1:0]       out_bram_addr,
  output logic                    out_bram_en,
  output logic                    out_bram_we,
  output logic [ACC_W-1:0]        out_bram_din,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err
);
  // lane index width; the block is built for exactly four lanes
  localparam int LANE_W = 2;
  localparam int PTR_W  = $clog2(LANE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q, rows_q;
  logic [ACC_W-1:0]  fifo_mem [N_MACS][LANE_DEPTH];
  logic [PTR_W-1:0]  wptr [N_MACS];
  logic [PTR_W-1:0]  rptr [N_MACS];
  logic [PTR_W:0]    fcnt [N_MACS];
  logic [ADDR_W-1:0] acc_cnt [N_MACS];
  logic [ADDR_W-1:0] row_cnt [N_MACS];
  logic [LANE_W-1:0] rr_ptr;

  logic [ACC_W-1:0]  lane_val [N_MACS];
  logic [N_MACS-1:0] fifo_empty, fifo_full, push, pop, extra, ovf;
  logic              grant_vld;
  logic [LANE_W-1:0] grant, idx;
  logic              job_start, all_done;
  logic [ADDR_W-1:0] wr_addr;

  assign job_start = start && (state == S_IDLE);
  assign wr_addr   = base_q + ADDR_W'(row_cnt[grant] * N_MACS) + ADDR_W'(grant);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign out_bram_we = out_bram_en;

  // lane values as pushed into the FIFOs (optionally ReLU-clamped)
  always_comb begin
    lane_val[0] = acc_in_0;
    lane_val[1] = acc_in_1;
    lane_val[2] = acc_in_2;
    lane_val[3] = acc_in_3;
`ifdef RESULT_MEM_WR_RELU_EN
    for (int l = 0; l < N_MACS; l++)
      if (lane_val[l][ACC_W-1]) lane_val[l] = '0;
`else
`endif
  end

  // FIFO occupancy flags
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    for (int l = 0; l < N_MACS; l++) begin
      fifo_empty[l] = (fcnt[l] == '0);
      fifo_full[l]  = (fcnt[l] == (PTR_W+1)'(LANE_DEPTH));
    end
  end

  // round-robin grant: lowest offset from rr_ptr wins, so scan from the top down
  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_ptr;
    idx       = rr_ptr;
    for (int i = N_MACS - 1; i >= 0; i--) begin
      idx = rr_ptr + LANE_W'(i);
      if (!fifo_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    pop = '0;
    if (state == S_RUN && grant_vld) pop[grant] = 1'b1;
  end

  // capture decision per lane; a full FIFO popped this cycle still accepts
  always_comb begin
    push  = '0;
    extra = '0;
    ovf   = '0;
    if (state == S_RUN) begin
      for (int l = 0; l < N_MACS; l++) begin
        if (valid_in[l]) begin
          if (acc_cnt[l] >= rows_q)          extra[l] = 1'b1;
          else if (fifo_full[l] && !pop[l])  ovf[l]   = 1'b1;
          else                               push[l]  = 1'b1;
        end
      end
    end
  end

  // job complete once every lane has written num_rows words and drained
  always_comb begin
    all_done = 1'b1;
    for (int l = 0; l < N_MACS; l++)
      if (row_cnt[l] != rows_q || !fifo_empty[l]) all_done = 1'b0;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_rows == '0) ? S_DONE : S_RUN;
      S_RUN:   if (all_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // job parameters and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      rows_q <= '0;
      err    <= '0;
    end else if (job_start) begin
      base_q <= base_addr;
      rows_q <= num_rows;
      err    <= '0;
    end else begin
      if (|ovf)   err[0] <= 1'b1;
      if (|extra) err[1] <= 1'b1;
    end
  end

  // FIFO pointers, per-lane accepted/written counters and RR pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < N_MACS; l++) begin
        wptr[l] <= '0; rptr[l] <= '0; fcnt[l] <= '0;
        acc_cnt[l] <= '0; row_cnt[l] <= '0;
      end
      rr_ptr <= '0;
    end else if (job_start) begin
      for (int l = 0; l < N_MACS; l++) begin
        wptr[l] <= '0; rptr[l] <= '0; fcnt[l] <= '0;
        acc_cnt[l] <= '0; row_cnt[l] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int l = 0; l < N_MACS; l++) begin
        if (push[l]) begin
          wptr[l]    <= wptr[l] + PTR_W'(1);
          acc_cnt[l] <= acc_cnt[l] + ADDR_W'(1);
        end
        if (pop[l]) begin
          rptr[l]    <= rptr[l] + PTR_W'(1);
          row_cnt[l] <= row_cnt[l] + ADDR_W'(1);
        end
        fcnt[l] <= fcnt[l] + (PTR_W+1)'(push[l]) - (PTR_W+1)'(pop[l]);
      end
      if (|pop) rr_ptr <= grant + LANE_W'(1);
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    for (int l = 0; l < N_MACS; l++)
      if (push[l]) fifo_mem[l][wptr[l]] <= lane_val[l];
  end

  // registered BRAM write port, enabled only in the cycle after a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bram_en   <= 1'b0;
      out_bram_addr <= '0;
      out_bram_din  <= '0;
    end else begin
      out_bram_en <= |pop;
      if (|pop) begin
        out_bram_addr <= wr_addr;
        out_bram_din  <= fifo_mem[grant][rptr[grant]];
      end
    end
  end

endmodule

// File: tb/tb_result_mem_wr.sv
// Directed self-checking bench for result_mem_wr.
`timescale 1ns/1ps
module tb_result_mem_wr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [7:0] num_rows = '0;
  logic signed [15:0] acc_in_0 = '0, acc_in_1 = '0, acc_in_2 = '0, acc_in_3 = '0;
  logic [3:0] valid_in = '0;
  logic [7:0] out_bram_addr;
  logic out_bram_en, out_bram_we;
  logic [15:0] out_bram_din;
  logic busy, done;
  logic [1:0] err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [7:0] wa[$];
  logic [15:0] wd[$];
  int wc[$];
  int we_bad = 0;
  int done_cyc = -1;
  logic busy_at_done = 1'b0;

  always #5 clk = ~clk;

  result_mem_wr dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .acc_in_0(acc_in_0), .acc_in_1(acc_in_1), .acc_in_2(acc_in_2), .acc_in_3(acc_in_3),
    .valid_in(valid_in), .out_bram_addr(out_bram_addr), .out_bram_en(out_bram_en),
    .out_bram_we(out_bram_we), .out_bram_din(out_bram_din), .busy(busy), .done(done),
    .err(err)
  );

  // write-port and done logger
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_bram_en) begin
      wa.push_back(out_bram_addr);
      wd.push_back(out_bram_din);
      wc.push_back(cyc);
    end
    if (out_bram_we !== out_bram_en) we_bad = we_bad + 1;
    if (done) begin
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cyc = -1;
  endtask

  task automatic pulse_start(input logic [7:0] b, input logic [7:0] n);
    start = 1'b1;
    base_addr = b;
    num_rows = n;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] m, input logic signed [15:0] d0, d1, d2, d3);
    valid_in = m;
    acc_in_0 = d0; acc_in_1 = d1; acc_in_2 = d2; acc_in_3 = d3;
    tick();
    valid_in = '0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    total_cnt++; if (out_bram_en !== 1'b0) $display("FAIL rst_en: got %b want 0", out_bram_en); else pass_cnt++;
    total_cnt++; if (out_bram_addr !== 8'd0) $display("FAIL rst_addr: got %0d want 0", out_bram_addr); else pass_cnt++;
    total_cnt++; if (out_bram_din !== 16'd0) $display("FAIL rst_din: got %0h want 0", out_bram_din); else pass_cnt++;
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done: got %b want 00", {busy, done}); else pass_cnt++;
    total_cnt++; if (err !== 2'b00) $display("FAIL rst_err: got %b want 00", err); else pass_cnt++;
    rst = 1'b0;
    clear_log();
    valid_in = 4'hF;
    acc_in_0 = 16'sd1; acc_in_1 = 16'sd2; acc_in_2 = 16'sd3; acc_in_3 = 16'sd4;
    repeat (5) tick();
    valid_in = '0;
    tick();
    total_cnt++; if (wa.size() != 0) $display("FAIL idle_writes: got %0d want 0", wa.size()); else pass_cnt++;
    total_cnt++; if (err !== 2'b00) $display("FAIL idle_err: got %b want 00", err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [4];
    bit ok;
    int c;
    exp_d[0] = 16'd5;
`ifdef RESULT_MEM_WR_RELU_EN
    exp_d[1] = 16'd0;
`else
    exp_d[1] = 16'hFFFD;
`endif
    exp_d[2] = 16'd7;
    exp_d[3] = 16'd9;
    clear_log();
    tick();
    pulse_start(8'd8, 8'd1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else pass_cnt++;
    c = cyc;
    strobe(4'hF, 16'sd5, -16'sd3, 16'sd7, 16'sd9);
    wait_done(30, ok);
    total_cnt++; if (!ok) $display("FAIL basic_timeout: done not seen within 30 cycles"); else pass_cnt++;
    total_cnt++; if (wa.size() != 4) $display("FAIL basic_count: got %0d want 4", wa.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wa.size() || wa[i] !== 8'(8 + i) || wd[i] !== exp_d[i])
        $display("FAIL basic_word%0d: got addr %0d data %0h want addr %0d data %0h", i,
                 (i < wa.size()) ? wa[i] : 8'hxx, (i < wd.size()) ? wd[i] : 16'hxxxx, 8 + i, exp_d[i]);
      else pass_cnt++;
    end
    if (wc.size() == 4) begin
      total_cnt++; if (wc[0] != c + 2) $display("FAIL basic_latency: got cycle %0d want %0d", wc[0], c + 2); else pass_cnt++;
      total_cnt++; if (wc[3] != wc[0] + 3) $display("FAIL basic_consecutive: got span %0d want 3", wc[3] - wc[0]); else pass_cnt++;
      total_cnt++; if (done_cyc != wc[3] + 1) $display("FAIL basic_done_time: got cycle %0d want %0d", done_cyc, wc[3] + 1); else pass_cnt++;
    end
    total_cnt++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); else pass_cnt++;
    total_cnt++; if (err !== 2'b00) $display("FAIL basic_err: got %b want 00", err); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    clear_log();
    tick();
    pulse_start(8'd254, 8'd1);
    strobe(4'hF, 16'sd10, 16'sd11, 16'sd12, 16'sd13);
    wait_done(30, ok);
    total_cnt++; if (!ok) $display("FAIL wrap_timeout: done not seen"); else pass_cnt++;
    total_cnt++; if (wa.size() != 4) $display("FAIL wrap_count: got %0d want 4", wa.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wa.size() || wa[i] !== 8'(254 + i) || wd[i] !== 16'(10 + i))
        $display("FAIL wrap_word%0d: got addr %0d data %0d want addr %0d data %0d", i,
                 (i < wa.size()) ? wa[i] : 8'hxx, (i < wd.size()) ? wd[i] : 16'hxxxx, 8'(254 + i), 10 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_rows();
    clear_log();
    tick();
    valid_in = 4'hF;
    pulse_start(8'd0, 8'd0);
    total_cnt++; if ({busy, done} !== 2'b01) $display("FAIL zero_done: got busy/done %b want 01", {busy, done}); else pass_cnt++;
    tick();
    valid_in = '0;
    total_cnt++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (wa.size() != 0) $display("FAIL zero_writes: got %0d want 0", wa.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    tick();
    pulse_start(8'd20, 8'd3);
    strobe(4'hF, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
    strobe(4'hF, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
    strobe(4'hF, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
    tick();
    total_cnt++; if (err !== 2'b01) $display("FAIL b2b_overflow_err: got %b want 01", err); else pass_cnt++;
    repeat (10) tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_still_busy: got %b want 1", busy); else pass_cnt++;
    strobe(4'b1100, 16'sd0, 16'sd0, 16'sd3, 16'sd4);
    wait_done(40, ok);
    total_cnt++; if (!ok) $display("FAIL b2b_timeout: done not seen"); else pass_cnt++;
    total_cnt++; if (wa.size() != 12) $display("FAIL b2b_count: got %0d want 12", wa.size()); else pass_cnt++;
    total_cnt++; if (err !== 2'b01) $display("FAIL b2b_err_hold: got %b want 01", err); else pass_cnt++;
  endtask

  task automatic test_spaced();
    bit ok;
    clear_log();
    tick();
    pulse_start(8'd40, 8'd3);
    for (int r = 0; r < 3; r++) begin
      strobe(4'hF, 16'(r * 100), 16'(r * 100 + 1), 16'(r * 100 + 2), 16'(r * 100 + 3));
      repeat (3) tick();
    end
    wait_done(40, ok);
    total_cnt++; if (!ok) $display("FAIL spaced_timeout: done not seen"); else pass_cnt++;
    total_cnt++; if (wa.size() != 12) $display("FAIL spaced_count: got %0d want 12", wa.size()); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      total_cnt++;
      if (i >= wa.size() || wa[i] !== 8'(40 + i) || wd[i] !== 16'((i / 4) * 100 + (i % 4)))
        $display("FAIL spaced_word%0d: got addr %0d data %0d want addr %0d data %0d", i,
                 (i < wa.size()) ? wa[i] : 8'hxx, (i < wd.size()) ? wd[i] : 16'hxxxx, 40 + i, (i / 4) * 100 + (i % 4));
      else pass_cnt++;
    end
    total_cnt++; if (err !== 2'b00) $display("FAIL spaced_err: got %b want 00", err); else pass_cnt++;
  endtask

  task automatic test_extra();
    bit ok;
    logic [7:0] ea [4];
    logic [15:0] ed [4];
    ea[0] = 8'd62; ea[1] = 8'd63; ea[2] = 8'd60; ea[3] = 8'd61;
    ed[0] = 16'd11; ed[1] = 16'd4; ed[2] = 16'd1; ed[3] = 16'd2;
    clear_log();
    tick();
    pulse_start(8'd60, 8'd1);
    strobe(4'b0100, 16'sd0, 16'sd0, 16'sd11, 16'sd0);
    strobe(4'b0100, 16'sd0, 16'sd0, 16'sd22, 16'sd0);
    repeat (5) tick();
    pulse_start(8'd200, 8'd5);
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL extra_wait_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (err !== 2'b10) $display("FAIL extra_err: got %b want 10", err); else pass_cnt++;
    strobe(4'b1011, 16'sd1, 16'sd2, 16'sd0, 16'sd4);
    wait_done(30, ok);
    total_cnt++; if (!ok) $display("FAIL extra_timeout: done not seen"); else pass_cnt++;
    total_cnt++; if (wa.size() != 4) $display("FAIL extra_count: got %0d want 4", wa.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i])
        $display("FAIL extra_word%0d: got addr %0d data %0d want addr %0d data %0d", i,
                 (i < wa.size()) ? wa[i] : 8'hxx, (i < wd.size()) ? wd[i] : 16'hxxxx, ea[i], ed[i]);
      else pass_cnt++;
    end
    total_cnt++; if (err !== 2'b10) $display("FAIL extra_err_hold: got %b want 10", err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    tick();
    pulse_start(8'd80, 8'd2);
    strobe(4'hF, 16'sd50, 16'sd51, 16'sd52, 16'sd53);
    for (int i = 0; i < 20; i++) begin
      if (wa.size() >= 2) break;
      tick();
    end
    total_cnt++; if (wa.size() != 2) $display("FAIL mid_two_writes: got %0d want 2", wa.size()); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (out_bram_en !== 1'b0) $display("FAIL mid_rst_en: got %b want 0", out_bram_en); else pass_cnt++;
    total_cnt++; if (out_bram_addr !== 8'd0) $display("FAIL mid_rst_addr: got %0d want 0", out_bram_addr); else pass_cnt++;
    total_cnt++; if (out_bram_din !== 16'd0) $display("FAIL mid_rst_din: got %0h want 0", out_bram_din); else pass_cnt++;
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL mid_rst_busy: got %b want 00", {busy, done}); else pass_cnt++;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    total_cnt++; if (wa.size() != 2) $display("FAIL mid_no_more_writes: got %0d want 2", wa.size()); else pass_cnt++;
    clear_log();
    pulse_start(8'd100, 8'd1);
    strobe(4'hF, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
    wait_done(30, ok);
    total_cnt++; if (!ok) $display("FAIL mid_rerun_timeout: done not seen"); else pass_cnt++;
    total_cnt++; if (wa.size() != 4) $display("FAIL mid_rerun_count: got %0d want 4", wa.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wa.size() || wa[i] !== 8'(100 + i) || wd[i] !== 16'(1 + i))
        $display("FAIL mid_rerun_word%0d: got addr %0d data %0d want addr %0d data %0d", i,
                 (i < wa.size()) ? wa[i] : 8'hxx, (i < wd.size()) ? wd[i] : 16'hxxxx, 100 + i, 1 + i);
      else pass_cnt++;
    end
    total_cnt++; if (err !== 2'b00) $display("FAIL mid_rerun_err: got %b want 00", err); else pass_cnt++;
    total_cnt++; if (we_bad != 0) $display("FAIL we_tracks_en: got %0d disagreeing cycles want 0", we_bad); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_rows();
    test_back_to_back();
    test_spaced();
    test_extra();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
